// File: rtl/fb_port_arbiter.sv
// Frame-buffer single-port arbiter: display fetch has priority, writer/host-reader share free slots round-robin.
// Optional FB_STALL_STATS_EN adds stall_cnt, counting writer stall cycles per frame.
module fb_port_arbiter #(
  parameter int          IMG_W    = 320,
  parameter int          IMG_H    = 240,
  parameter int          X_OFF    = 160,
  parameter int          Y_OFF    = 120,
  parameter int          ADDR_W   = 17,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              display_en,
  input  logic              vga_active,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  output logic [7:0]        color_out,
  output logic              scan_on,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
`ifdef FB_STALL_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              rd_data_valid
);

  localparam int FB_SIZE = IMG_W * IMG_H;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SCAN, DRAIN} state_t;

  state_t            state_q;
  logic              prefer_wr_q;
  logic              disp_q;
  logic              rd_own_q;
  logic              rd_oor_q;

  logic              frame_start;
  logic              in_win;
  logic              disp_slot;
  logic              wr_grant;
  logic              rd_grant;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [31:0]       x32;
  logic [31:0]       y32;
  logic [ADDR_W-1:0] dx;
  logic [ADDR_W-1:0] dy;
  logic [ADDR_W-1:0] disp_addr;

  assign x32         = 32'(next_x);
  assign y32         = 32'(next_y);
  assign frame_start = vga_active && (next_x == 10'd0) && (next_y == 10'd0);
  assign in_win      = vga_active
                       && (x32 >= 32'(X_OFF)) && (x32 < 32'(X_OFF + IMG_W))
                       && (y32 >= 32'(Y_OFF)) && (y32 < 32'(Y_OFF + IMG_H));
  assign disp_slot   = !reset && in_win && (state_q == SCAN);

  assign dx          = ADDR_W'(next_x) - ADDR_W'(X_OFF);
  assign dy          = ADDR_W'(next_y) - ADDR_W'(Y_OFF);
  assign disp_addr   = dy * ADDR_W'(IMG_W) + dx;

  assign wr_in_range = 32'(wr_addr) < 32'(FB_SIZE);
  assign rd_in_range = 32'(rd_addr) < 32'(FB_SIZE);

  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (!reset && !disp_slot) begin
      if (wr_valid && rd_valid) begin
        wr_grant = prefer_wr_q;
        rd_grant = !prefer_wr_q;
      end else begin
        wr_grant = wr_valid;
        rd_grant = rd_valid;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    if (disp_slot)     mem_addr = disp_addr;
    else if (wr_grant) mem_addr = wr_addr;
    else if (rd_grant) mem_addr = rd_addr;
  end

  assign mem_we    = wr_grant && wr_in_range;
  assign mem_wdata = wr_grant ? wr_data : 8'h00;
  assign wr_ready  = wr_grant;
  assign rd_ready  = rd_grant;
  assign scan_on   = (state_q == SCAN);

  // The RAM read port already adds the one-cycle latency; ownership flops steer its data.
  assign color_out     = disp_q ? mem_rdata : BG_COLOR;
  assign rd_data_valid = rd_own_q && !reset;
  assign rd_data       = (rd_own_q && !rd_oor_q) ? mem_rdata : 8'h00;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prefer_wr_q <= 1'b1;
      disp_q      <= 1'b0;
      rd_own_q    <= 1'b0;
      rd_oor_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE:       if (display_en) state_q <= WAIT_FRAME;
        WAIT_FRAME: if (!display_en) state_q <= IDLE;
                    else if (frame_start) state_q <= SCAN;
        SCAN:       if (frame_start && !display_en) state_q <= DRAIN;
        DRAIN:      state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
      if (wr_valid && rd_valid && !disp_slot) prefer_wr_q <= !prefer_wr_q;
      disp_q   <= disp_slot;
      rd_own_q <= rd_grant;
      rd_oor_q <= rd_grant && !rd_in_range;
    end
  end

`ifdef FB_STALL_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset || frame_start) stall_q <= '0;
    else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: per-cycle expectations from a spec-level model, checked by a separate monitor.
module tb_fb_port_arbiter;

  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SCAN = 2, PH_DRAIN = 3;
  localparam int FB = 320 * 240;
  localparam logic [7:0] BG = 8'h00;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        display_en = 1'b0, vga_active = 1'b0;
  logic [9:0]  next_x = '0, next_y = '0;
  logic [7:0]  color_out, mem_wdata, mem_rdata, wr_data = '0, rd_data;
  logic        scan_on, mem_we, wr_valid = 1'b0, wr_ready, rd_valid = 1'b0, rd_ready, rd_data_valid;
  logic [16:0] mem_addr, wr_addr = '0, rd_addr = '0;
`ifdef FB_STALL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fb_port_arbiter dut (
    .clock(clock), .reset(reset), .display_en(display_en), .vga_active(vga_active),
    .next_x(next_x), .next_y(next_y), .color_out(color_out), .scan_on(scan_on),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
`ifdef FB_STALL_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .rd_data_valid(rd_data_valid)
  );

  always #5 clock = ~clock;

  // Frame-buffer RAM with one-cycle synchronous read.
  logic [7:0] ram [0:131071];
  always @(posedge clock) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  typedef struct {
    bit          rst;
    bit          wr_rdy;
    bit          rd_rdy;
    bit          we;
    bit          chk_addr;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  color;
    bit          scan;
    bit          rdv;
    int          stall;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  int checks = 0, failures = 0;

  // Reference model state
  logic [7:0]  model_ram [0:131071];
  int          m_phase;
  bit          m_pref_wr, m_prev_disp, m_prev_rd;
  logic [7:0]  m_prev_val;
  int          m_stall;

  // Requester state (held until the model grants)
  bit          wr_pend = 0, rd_pend = 0;
  logic [16:0] wr_a = '0, rd_a = '0;
  logic [7:0]  wr_d = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endfunction

  task automatic step(input bit rst, input bit en, input bit va, input int x, input int y);
    exp_t e;
    bit   fs, inwin, disp, wg, rg;
    int   a;
    @(posedge clock); #1;
    reset = rst; display_en = en; vga_active = va;
    next_x = 10'(x); next_y = 10'(y);
    wr_valid = wr_pend; wr_addr = wr_a; wr_data = wr_d;
    rd_valid = rd_pend; rd_addr = rd_a;
    e.rst = rst; e.wr_rdy = 0; e.rd_rdy = 0; e.we = 0; e.chk_addr = 0;
    e.addr = '0; e.wdata = '0;
    e.color = m_prev_disp ? m_prev_val : BG;
    e.scan  = (m_phase == PH_SCAN);
    e.rdv   = m_prev_rd;
    e.stall = m_stall;
    if (rst) begin
      m_phase = PH_IDLE; m_pref_wr = 1; m_prev_disp = 0; m_prev_rd = 0; m_stall = 0;
      rd_q.delete();
      wr_pend = 0; rd_pend = 0;
      exp_q.push_back(e);
      return;
    end
    fs    = va && x == 0 && y == 0;
    inwin = va && x >= 160 && x < 480 && y >= 120 && y < 360;
    disp  = inwin && m_phase == PH_SCAN;
    wg = 0; rg = 0;
    if (disp) begin
      a = (y - 120) * 320 + (x - 160);
      e.chk_addr = 1; e.addr = 17'(a);
      m_prev_val = model_ram[a];
    end else if (wr_pend && rd_pend) begin
      wg = m_pref_wr; rg = !m_pref_wr; m_pref_wr = !m_pref_wr;
    end else begin
      wg = wr_pend; rg = rd_pend;
    end
    e.wr_rdy = wg; e.rd_rdy = rg;
    if (wg) begin
      e.chk_addr = 1; e.addr = wr_a;
      if (int'(wr_a) < FB) begin
        e.we = 1; e.wdata = wr_d; model_ram[wr_a] = wr_d;
      end
    end
    if (rg) begin
      e.chk_addr = 1; e.addr = rd_a;
      rd_q.push_back(int'(rd_a) < FB ? model_ram[rd_a] : 8'h00);
    end
    if (fs) m_stall = 0;
    else if (wr_pend && !wg && m_stall < 65535) m_stall++;
    case (m_phase)
      PH_IDLE:  if (en) m_phase = PH_WAIT;
      PH_WAIT:  if (!en) m_phase = PH_IDLE; else if (fs) m_phase = PH_SCAN;
      PH_SCAN:  if (fs && !en) m_phase = PH_DRAIN;
      default:  m_phase = PH_IDLE;
    endcase
    m_prev_disp = disp; m_prev_rd = rg;
    if (wg) wr_pend = 0;
    if (rg) rd_pend = 0;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle's outputs mid-cycle, pops read data on each rd_data_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.rst) begin
          chk("rdv_in_reset", rd_data_valid, 0);
          chk("wr_ready_in_reset", wr_ready, 0);
          chk("mem_we_in_reset", mem_we, 0);
        end else begin
          chk("wr_ready", wr_ready, e.wr_rdy);
          chk("rd_ready", rd_ready, e.rd_rdy);
          chk("mem_we", mem_we, e.we);
          if (e.chk_addr) chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          chk("color_out", color_out, e.color);
          chk("scan_on", scan_on, e.scan);
          chk("rd_data_valid", rd_data_valid, e.rdv);
`ifdef FB_STALL_STATS_EN
          chk("stall_cnt", stall_cnt, e.stall);
`endif
          if (rd_data_valid) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", rd_data, rd_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int  r, x, y;
    bit  en, va;
    for (int i = 0; i < 131072; i++) begin
      ram[i] = 8'(i);
      model_ram[i] = 8'(i);
    end
    repeat (3) step(1, 0, 0, 0, 0);

    // Enable, wait for frame start, then scan a window row with a stalled writer.
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int xi = 150; xi <= 485; xi++) begin
      if (xi == 170) begin wr_pend = 1; wr_a = 17'd5; wr_d = 8'hAA; end
      step(0, 1, 1, xi, 120);
    end
    step(0, 1, 1, 0, 0);
    for (int xi = 158; xi <= 170; xi++) step(0, 1, 1, xi, 120);

    // Contested free slots: writer and reader both re-arm every cycle.
    for (int k = 0; k < 6; k++) begin
      if (!wr_pend) begin wr_pend = 1; wr_a = 17'(100 + k); wr_d = 8'(8'h30 + k); end
      if (!rd_pend) begin rd_pend = 1; rd_a = 17'(100 + k); end
      step(0, 1, 1, 10, 10);
    end
    repeat (3) step(0, 1, 1, 10, 10);

    // Out-of-range write then read at the first illegal address.
    wr_pend = 1; wr_a = 17'(FB); wr_d = 8'h55;
    step(0, 1, 0, 5, 5);
    rd_pend = 1; rd_a = 17'(FB);
    step(0, 1, 0, 5, 5);
    step(0, 1, 0, 5, 5);

    // Disable mid-frame: scan continues until next frame start, then drain and idle.
    for (int xi = 200; xi < 210; xi++) step(0, 0, 1, xi, 200);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 300, 200);
    wr_pend = 1; wr_a = 17'd7; wr_d = 8'h77;
    rd_pend = 1; rd_a = 17'd320;
    for (int xi = 300; xi < 306; xi++) step(0, 0, 1, xi, 200);

    // Randomized traffic.
    en = 1;
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 59) == 0) en = !en;
      if (!wr_pend && $urandom_range(0, 2) == 0) begin
        wr_pend = 1;
        wr_a = ($urandom_range(0, 9) == 0) ? 17'(FB + $urandom_range(0, 100)) : 17'($urandom_range(0, FB - 1));
        wr_d = 8'($urandom);
      end
      if (!rd_pend && $urandom_range(0, 2) == 0) begin
        rd_pend = 1;
        rd_a = ($urandom_range(0, 9) == 0) ? 17'(FB + $urandom_range(0, 100)) : 17'($urandom_range(0, FB - 1));
      end
      r = $urandom_range(0, 99);
      if (r < 3) begin
        va = 1; x = 0; y = 0;
      end else if (r < 50) begin
        va = 1; x = 160 + $urandom_range(0, 319); y = 120 + $urandom_range(0, 239);
      end else if (r < 65) begin
        va = 1;
        case ($urandom_range(0, 5))
          0: x = 0;  1: x = 159; 2: x = 160; 3: x = 479; 4: x = 480; default: x = 799;
        endcase
        case ($urandom_range(0, 3))
          0: y = 119; 1: y = 120; 2: y = 359; default: y = 360;
        endcase
      end else begin
        va = 1'($urandom_range(0, 1)); x = $urandom_range(0, 799); y = $urandom_range(0, 524);
      end
      step(($urandom_range(0, 699) == 0), en, va, x, y);
    end

    wr_pend = 0; rd_pend = 0;
    repeat (3) step(0, 0, 0, 1, 1);
    repeat (2) @(posedge clock);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Owns the single port of the on-chip frame-buffer RAM (8-bit RRRGGGBB pixels) and shares it between three requesters: the VGA display fetch, the zoom-engine pixel writer and the host read-back path. The display fetch has absolute priority whenever the scan position is inside the image window, and it returns pixel colour to the VGA driver. Free slots go round-robin to the writer and the host reader. Display enable is frame-synchronised so enabling or disabling the display never tears the picture.

Parameters:
IMG_W, 320, image width in pixels
IMG_H, 240, image height in lines
X_OFF, 160, window left edge in screen pixels
Y_OFF, 120, window top edge in screen lines
ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
BG_COLOR, 8'h00, colour output outside the window or when display is disabled

Ports:
clock  in  1  pixel clock, 25 MHz
reset  in  1  synchronous, active-high
display_en  in  1  request display on or off; takes effect at the next frame start
vga_active  in  1  high when next_x/next_y address an active pixel
next_x  in  10  next screen x from the VGA driver
next_y  in  10  next screen y from the VGA driver
color_out  out  8  pixel colour to the VGA driver
scan_on  out  1  FSM is in SCAN
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write strobe
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid 1 cycle after the address
wr_valid  in  1  writer request
wr_ready  out  1  write accepted this cycle
wr_addr  in  ADDR_W  writer address
wr_data  in  8  writer pixel
rd_valid  in  1  host read request
rd_ready  out  1  read accepted this cycle
rd_addr  in  ADDR_W  host read address
rd_data  out  8  host read data
rd_data_valid  out  1  rd_data valid pulse

Behaviour:
- Reset values: color_out=BG_COLOR; scan_on, mem_we, wr_ready, rd_ready, rd_data_valid all 0; rd_data=0; mem_addr=0; FSM in IDLE; round-robin pointer favours the writer.
- Frame start: vga_active=1 with next_x=0 and next_y=0.
- FSM:
  - IDLE → WAIT_FRAME when display_en=1.
  - WAIT_FRAME → SCAN on frame start while display_en=1.
  - WAIT_FRAME → IDLE if display_en drops before frame start.
  - SCAN → DRAIN on frame start while display_en=0.
  - DRAIN → IDLE after one cycle, which lets the last display read return.
- in_win = vga_active & x in [X_OFF, X_OFF+IMG_W-1] & y in [Y_OFF, Y_OFF+IMG_H-1], where x = next_x and y = next_y.
- Display slot: taken when in_win and the state is SCAN.
  - mem_addr = (next_y-Y_OFF)*IMG_W + (next_x-X_OFF), computed in ADDR_W bits.
  - An incremental line-base counter is allowed if it gives the same result.
  - mem_we=0; wr_ready=0; rd_ready=0.
- Free slot: any cycle without a display slot.
  - Only wr_valid: grant the writer.
  - Only rd_valid: grant the reader.
  - Both valid: grant the side not granted last; update the pointer only on a contested grant.
  - Write grant: wr_ready=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. The transfer completes in that cycle.
  - Read grant: rd_ready=1, mem_addr=rd_addr. rd_data_valid=1 exactly one cycle later, with rd_data=mem_rdata.
- Range check: an address >= IMG_W*IMG_H is still acknowledged (ready=1).
  - Write: mem_we stays 0.
  - Read: rd_data=0.
- Requesters must hold valid and payload stable until ready. The arbiter has no queue and never drops an accepted request.
- Read-slot ownership is registered for one cycle. This register routes mem_rdata back to either color_out or rd_data.
- color_out: registered, 1-cycle latency.
  - Equals mem_rdata if the previous cycle was a display slot.
  - Otherwise equals BG_COLOR.
- reset mid-operation: any in-flight read result is discarded (no rd_data_valid), and the FSM returns to IDLE.

Optional Feature:
FB_STALL_STATS_EN:
- Defined: adds output stall_cnt (16 bits).
  - Increments each cycle that wr_valid=1 and wr_ready=0.
  - Saturates at 16'hFFFF.
  - Clears on reset and at each frame start.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, display_en=1, run 2 frames, RAM preloaded with addr[7:0]: scan_on rises at the first frame start. At screen (160,120), color_out=8'h00 one cycle later; at (161,120), 8'h01. Outside the window, color_out=BG_COLOR.
- Hold wr_valid with wr_addr=5, wr_data=8'hAA while the scan is inside the window: wr_ready=0 throughout. At the first out-of-window cycle, wr_ready=1 and mem_we=1 with addr 5; a later display of pixel (165,120) shows 8'hAA.
- wr_valid and rd_valid held together through 4 free cycles: grants alternate W,R,W,R. Each read gives rd_data_valid one cycle after rd_ready.
- Write to addr 76800 (IMG_W*IMG_H): wr_ready=1, mem_we=0. Read of addr 76800: rd_data_valid=1, rd_data=0.
- display_en cleared mid-frame: SCAN continues until the next frame start, then DRAIN for 1 cycle, then IDLE. After that, color_out=BG_COLOR and every cycle is a free slot.
- FB_STALL_STATS_EN defined, wr_valid held across a 320-pixel in-window span: stall_cnt=320 at span end, and 0 after the next frame start.
